// File: rtl/squash_input_conditioner.sv
// Player-control conditioner for solo_squash: per-channel sync, debounce,
// press pulses, pause toggle latch and up/down conflict arbitration.
module squash_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PAUSE_TOGGLE    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pause_n_in,
    input  logic       new_game_n_in,
    input  logic       up_key_n_in,
    input  logic       down_key_n_in,
    output logic       pause_n,
    output logic       new_game_n,
    output logic       up_key_n,
    output logic       down_key_n,
    output logic [3:0] press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_d;
    logic [3:0]    fall;
    logic [CW-1:0] cnt [4];
    logic          latch;
    logic          latch_nxt;
    logic          conflict;
    logic          pause_q;
    logic          new_game_q;
    logic          up_q;
    logic          down_q;
    logic [3:0]    press_q;

    assign raw = {down_key_n_in, up_key_n_in, new_game_n_in, pause_n_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle of agreement with the debounced state restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = deb_d & ~deb;

    // New-game clear dominates a simultaneous pause press
    always_comb begin
        latch_nxt = latch;
        if (fall[1]) begin
            latch_nxt = 1'b0;
        end else if (fall[0]) begin
            latch_nxt = ~latch;
        end
    end

    assign conflict = ~deb[2] & ~deb[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d      <= 4'hF;
            press_q    <= 4'h0;
            latch      <= 1'b0;
            pause_q    <= 1'b1;
            new_game_q <= 1'b1;
            up_q       <= 1'b1;
            down_q     <= 1'b1;
        end else begin
            deb_d      <= deb;
            press_q    <= fall;
            latch      <= latch_nxt;
            pause_q    <= (PAUSE_TOGGLE != 0) ? ~latch_nxt : deb[0];
            new_game_q <= deb[1];
            up_q       <= deb[2] | conflict;
            down_q     <= deb[3] | conflict;
        end
    end

    assign pause_n    = pause_q;
    assign new_game_n = new_game_q;
    assign up_key_n   = up_q;
    assign down_key_n = down_q;
    assign press      = press_q;

endmodule
